// File: rtl/dm_sized_if.sv
// dm_sized_if: request/response bundle between the MEM stage and dm_sized
interface dm_sized_if;
  logic        Req;
  logic        WE;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [31:0] PC;
  logic [31:0] RData;
  logic        RValid;
  logic        Ready;
  logic        AdEL;
  logic        AdES;
  modport master (
    output Req, WE, Size, Unsigned, Addr, WData, PC,
    input  RData, RValid, Ready, AdEL, AdES
  );
  modport slave (
    input  Req, WE, Size, Unsigned, Addr, WData, PC,
    output RData, RValid, Ready, AdEL, AdES
  );
endinterface

// File: rtl/dm_sized.sv
// dm_sized: byte/half/word data memory with clear-on-reset sweep; define DM_TRACE_EN to print committed stores
module dm_sized #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic         clk,
  input  logic         Reset,
  dm_sized_if.slave    bus
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t                state, state_nx;
  logic [DEPTH_LOG2-1:0] ptr, idx, waddr;
  logic [31:0]           mem [2**DEPTH_LOG2];
  logic [31:0]           raw, wdat, ld;
  logic [15:0]           hw;
  logic [7:0]            bt;
  logic [4:0]            sh;
  logic [3:0]            be, wbe;
  logic                  is_half, is_word, mis, go, st, ldv, clr;
  logic                  unused_bits;
  assign unused_bits = ^{bus.PC, bus.Addr[31:DEPTH_LOG2+2]};
  always_ff @(posedge clk) begin
    state <= Reset ? CLEAR : state_nx;
    ptr   <= Reset ? '0 : clr ? ptr + 1'b1 : ptr;
  end
  always_comb begin
    state_nx  = (state == CLEAR && ptr == '1) ? RUN : state;
    bus.Ready = state == RUN;
    clr       = state == CLEAR && !Reset;
    idx       = bus.Addr[DEPTH_LOG2+1:2];
    sh        = {bus.Addr[1:0], 3'b000};
    is_word   = bus.Size[1];
    is_half   = bus.Size == 2'b01;
    mis       = is_word ? |bus.Addr[1:0] : is_half & bus.Addr[0];
    go        = bus.Ready & bus.Req & !Reset;
    st        = go & bus.WE & !mis;
    ldv       = go & !bus.WE & !mis;
    be        = is_word ? 4'hF : is_half ? (bus.Addr[1] ? 4'hC : 4'h3) : 4'b0001 << bus.Addr[1:0];
    wbe       = clr ? 4'hF : st ? be : 4'h0;
    waddr     = clr ? ptr : idx;
    // store data is replicated across lanes so the byte enables alone pick the target
    wdat      = clr ? '0 : is_word ? bus.WData : is_half ? {2{bus.WData[15:0]}} : {4{bus.WData[7:0]}};
    raw       = mem[idx];
    bt        = raw[sh +: 8];
    hw        = bus.Addr[1] ? raw[31:16] : raw[15:0];
    ld        = is_word ? raw : is_half ? {{16{!bus.Unsigned & hw[15]}}, hw} : {{24{!bus.Unsigned & bt[7]}}, bt};
  end
  always_ff @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (wbe[b]) mem[waddr][8*b +: 8] <= wdat[8*b +: 8];
  always_ff @(posedge clk) begin
    if (Reset) begin
      bus.RData  <= '0;
      bus.RValid <= 1'b0;
      bus.AdEL   <= 1'b0;
      bus.AdES   <= 1'b0;
    end else begin
      bus.RValid <= ldv;
      bus.AdEL   <= go & !bus.WE & mis;
      bus.AdES   <= go & bus.WE & mis;
      if (ldv) bus.RData <= ld;
    end
  end
`ifdef DM_TRACE_EN
  logic [31:0] merged;
  always_comb begin
    merged = raw;
    for (int b = 0; b < 4; b++)
      if (be[b]) merged[8*b +: 8] = wdat[8*b +: 8];
  end
  always_ff @(posedge clk)
    if (st) $display("@%08h: *%08h <= %08h", bus.PC, {bus.Addr[31:2], 2'b00}, merged);
`else
`endif
endmodule

// File: tb/tb_dm_sized.sv
// tb_dm_sized: randomized scoreboard bench for dm_sized against a word-array reference model
module tb_dm_sized;
  typedef struct {
    logic        rdy;
    logic        rv;
    logic        el;
    logic        es;
    logic [31:0] rd;
  } exp_t;
  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] m [16];
  logic [31:0] last = '0;
  int          cnt = 16;
  int          tests = 0;
  int          fails = 0;
  exp_t        sb [$];
  dm_sized_if bus ();
  dm_sized #(.DEPTH_LOG2(4)) dut (.clk(clk), .Reset(Reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    bus.Req = 0; bus.WE = 0; bus.Size = 0; bus.Unsigned = 0;
    bus.Addr = 0; bus.WData = 0; bus.PC = 0;
    for (int i = 0; i < 16; i++) m[i] = '0;
  end
  // reference: 16 words, sweep pending count, last loaded value
  task automatic step(input logic r, input logic q, input logic we, input logic [1:0] sz,
                      input logic u, input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] v, mk;
    int          nb, sh, wi;
    @(negedge clk);
    Reset = r; bus.Req = q; bus.WE = we; bus.Size = sz; bus.Unsigned = u;
    bus.Addr = a; bus.WData = wd; bus.PC = $urandom;
    e.rv = 0; e.el = 0; e.es = 0;
    if (r) begin
      cnt = 16;
      last = '0;
    end else if (cnt > 0) begin
      m[16 - cnt] = '0;
      cnt--;
    end else if (q) begin
      nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      wi = (a / 4) % 16;
      if ((a % nb) != 0) begin
        e.el = !we;
        e.es = we;
      end else begin
        sh = 8 * (a % 4);
        mk = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 1) << sh;
        if (we) m[wi] = (m[wi] & ~mk) | ((wd << sh) & mk);
        else begin
          v = (m[wi] & mk) >> sh;
          if (!u && nb < 4 && v[8*nb-1]) v = v | ~(mk >> sh);
          last = v;
          e.rv = 1;
        end
      end
    end
    e.rdy = (cnt == 0) && !r;
    e.rd = last;
    sb.push_back(e);
  endtask
  task automatic idle();
    step(0, 0, 0, 2'b00, 0, 32'h0, 32'h0);
  endtask
  task automatic st(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    step(0, 1, 1, sz, 0, a, wd);
  endtask
  task automatic ld(input logic [31:0] a, input logic [1:0] sz, input logic u);
    step(0, 1, 0, sz, u, a, $urandom);
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if ({bus.Ready, bus.RValid, bus.AdEL, bus.AdES, bus.RData} !== {e.rdy, e.rv, e.el, e.es, e.rd}) begin
        fails++;
        $display("FAIL resp @%0t: got rdy=%b rv=%b adel=%b ades=%b rdata=%08h, want rdy=%b rv=%b adel=%b ades=%b rdata=%08h",
                 $time, bus.Ready, bus.RValid, bus.AdEL, bus.AdES, bus.RData, e.rdy, e.rv, e.el, e.es, e.rd);
      end
    end
  end
  initial begin
    step(1, 0, 0, 2'b00, 0, 32'h0, 32'h0);
    repeat (16) idle();
    for (int a = 0; a <= 'h3C; a += 4) ld(a, 2'b10, 0);
    st(32'h8, 2'b10, 32'h11223344);
    st(32'hA, 2'b00, 32'h000000AB);
    ld(32'h8, 2'b10, 0);
    ld(32'hA, 2'b00, 0);
    ld(32'hA, 2'b00, 1);
    st(32'h6, 2'b01, 32'h00008001);
    ld(32'h6, 2'b01, 0);
    ld(32'h6, 2'b01, 1);
    ld(32'h4, 2'b10, 0);
    st(32'h0, 2'b10, 32'hCAFEF00D);
    st(32'h2, 2'b10, 32'hDEADBEEF);
    ld(32'h0, 2'b10, 0);
    ld(32'h5, 2'b01, 0);
    ld(32'h3, 2'b11, 0);
    st(32'h4, 2'b10, 32'h5A5A1234);
    ld(32'h4, 2'b10, 0);
    st(32'h44, 2'b10, 32'h0BADCAFE);
    ld(32'h4, 2'b10, 0);
    ld(32'h47, 2'b00, 0);
    step(1, 1, 1, 2'b10, 0, 32'h0, 32'hFFFFFFFF);
    repeat (7) idle();
    step(1, 0, 0, 2'b00, 0, 32'h0, 32'h0);
    repeat (3) idle();
    st(32'h30, 2'b10, 32'h12345678);
    repeat (12) idle();
    ld(32'h30, 2'b10, 0);
    ld(32'h0, 2'b10, 0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 299) == 0) step(1, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
      else step(0, 1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), 1'($urandom),
                ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127)), $urandom);
    end
    idle();
    @(posedge clk);
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dm_sized.md
# dm_sized

Parametrised data memory for the MIPS datapath with byte, halfword and word loads and stores, and sign or zero extension on loads. Loads are registered with one-cycle latency. Alignment exceptions are flagged instead of silently writing. Reset clears the array through a sweep state machine, one word per cycle, so the block maps to single-port RAM. It sits in the MEM stage; `Ready` stalls the pipeline while the clear is running.

## Interface
- `DEPTH_LOG2`, default 10: number of address bits. The memory holds 2^DEPTH_LOG2 32-bit words.

- `clk`  in  1  clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Req`  in  1  access request, valid this cycle.
- `WE`  in  1  1 = store, 0 = load; qualified by `Req`.
- `Size`  in  2  access size: 00 byte, 01 half, 10 word; 11 is reserved and handled as word.
- `Unsigned`  in  1  load extension: 1 zero-extends, 0 sign-extends; ignored for word accesses.
- `Addr`  in  32  byte address. Word index is `Addr[DEPTH_LOG2+1:2]`; higher bits are ignored.
- `WData`  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- `PC`  in  32  PC of the accessing instruction; used for trace only.
- `RData`  out  32  extended load data; valid when `RValid` = 1.
- `RValid`  out  1  one-cycle pulse, one cycle after an accepted load.
- `Ready`  out  1  1 when the block accepts requests; 0 during the clear sweep.
- `AdEL`  out  1  one-cycle pulse: misaligned load.
- `AdES`  out  1  one-cycle pulse: misaligned store.

## Operation
- **States:** CLEAR and RUN.
  - Any cycle with `Reset` = 1: state becomes CLEAR and `ptr` = 0. All outputs are registered to 0 (`RData`, `RValid`, `AdEL`, `AdES`), and `Ready` = 0.
  - In CLEAR with `Reset` = 0: each edge writes `mem[ptr]` = 0 and increments `ptr`. The edge that writes word 2^DEPTH_LOG2 − 1 moves the state to RUN.
  - `Ready` = (state == RUN).
- **Reset during CLEAR:** the sweep restarts at `ptr` = 0. Words already cleared stay cleared.
- **Requests while `Ready` = 0:** ignored. No write, no `RValid`, no exception flag.
- **Alignment:**
  - Half access is misaligned when `Addr[0]` = 1.
  - Word access (including Size 11) is misaligned when `Addr[1:0]` ≠ 0.
  - Byte access is never misaligned.
  - A misaligned access does not touch the memory or `RData`. It pulses `AdEL` (load) or `AdES` (store) on the next cycle.
- **Store (little-endian):**
  - Byte: lane `Addr[1:0]` receives `WData[7:0]`.
  - Half: lanes {`Addr[1]`, 1}/{`Addr[1]`, 0} receive `WData[15:0]`.
  - Word: all lanes are written.
  - Lanes that are not selected keep their value.
- **Load:**
  - Selects the same lane(s) as a store of the same size.
  - Extends to 32 bits according to `Unsigned`.
  - Registers the result into `RData` and pulses `RValid`.
- **Holding:** `RData` holds its last value until the next accepted load.

## Timing
- Load latency is 1: a request at edge N gives `RData`/`RValid` after edge N.
- Store commits at the request edge.
- A load in the cycle after a store to the same word returns the new data.
- `Req` may be asserted every cycle: one access per cycle with full throughput.
- The clear takes exactly 2^DEPTH_LOG2 cycles after the last `Reset` = 1 cycle. `Ready` rises after the final sweep edge.
- Exception pulses have the same 1-cycle latency as `RValid`. `RValid` and `AdEL` are never asserted together.

## Configuration
- `DM_TRACE_EN` defined: each committed store prints `@<PC>: *<Addr with [1:0] zeroed> <= <merged 32-bit word after write>` using `$display`, with 8-digit hex fields.
- `DM_TRACE_EN` undefined: no display. Behaviour is otherwise identical.

## Test plan
All scenarios use `DEPTH_LOG2` = 4.
- **Clear:** Reset for 1 cycle, then idle.
  - `Ready` = 0 for 16 cycles, then 1.
  - A word load of every address 0x00–0x3C returns 0x00000000.
- **Byte stores:** store word 0x11223344 @0x8, then store byte 0xAB @0xA.
  - Word load @0x8 returns 0x11AB3344.
  - Signed byte load @0xA returns 0xFFFFFFAB; unsigned returns 0x000000AB.
- **Halfword:** store half 0x8001 @0x6.
  - Signed half load @0x6 returns 0xFFFF8001; unsigned returns 0x00008001.
  - Word load @0x4 returns 0x80010000.
- **Misaligned:**
  - Word store @0x2 gives an `AdES` pulse; a following word load @0x0 returns the unchanged value.
  - Half load @0x5 gives an `AdEL` pulse with `RValid` = 0.
- **Reset mid-sweep:** assert Reset at sweep cycle 7.
  - `Ready` stays 0 for 16 more cycles.
  - A `Req` store during the sweep has no effect; the word reads 0.
- **Back-to-back and aliasing:** store @0x4 then load @0x4 in consecutive cycles returns the new data. Address 0x44 aliases to word 1.
